pixel_scan_ctrl: RTL and testbench
==================================

# pixel_scan_ctrl

Sequencer for the pixel output path. It enables the pixel-rate clock divider and converts its toggling `flag_pixel` into one-cycle ticks. It walks a raster of active and blanking positions and pulls one pixel per active tick from the upstream pixel source through a valid/ready handshake. It sits between the frame/pixel source and the serializer, and owns start/stop of frame scanning.

## Interface
- H_ACTIVE, 8, active pixels per line
- H_BLANK, 2, blanking ticks per line; H_TOTAL = H_ACTIVE + H_BLANK
- V_ACTIVE, 6, active lines per frame
- V_BLANK, 2, blanking lines per frame; V_TOTAL = V_ACTIVE + V_BLANK
- DATA_W, 8, pixel width
- clk  in  1  system clock
- n_rst  in  1  asynchronous, active-low reset
- start  in  1  begin scanning (honoured only in IDLE)
- stop  in  1  request stop at end of current frame
- pix_flag  in  1  `flag_pixel` from clock divider (toggles once per pixel period)
- pix_valid  in  1  upstream pixel available
- pix_data  in  DATA_W  upstream pixel
- div_enable  out  1  clock-divider enable
- pix_ready  out  1  one-cycle pop strobe to upstream
- pix_out  out  DATA_W  registered current pixel
- hblank  out  1  high in HBLANK
- vblank  out  1  high in VBLANK
- frame_done  out  1  one-cycle pulse at frame end
- underrun  out  1  sticky: active tick with pix_valid low
- busy  out  1  state != IDLE
- col  out  clog2(H_TOTAL)  current column
- row  out  clog2(V_TOTAL)  current row

## Operation
- tick = pix_flag XOR pix_flag_q (combinational); pix_flag_q is registered every cycle and resets to 0.
- States: IDLE, ACTIVE, HBLANK, VBLANK. State, col and row change only on tick, except for start.
- IDLE: if start is high, go to ACTIVE with col=0, row=0, and clear underrun. start outside IDLE is ignored.
- ACTIVE tick:
  - Consume pixel (row, col): if pix_valid, pix_ready=1 (combinational, that cycle only) and pix_out <= pix_data.
  - Else pix_out <= 0, underrun <= 1, pix_ready stays 0.
  - Then col++. If col == H_ACTIVE-1, go to HBLANK.
- HBLANK tick: col++. At col == H_TOTAL-1: col <= 0 and row++. Next state is ACTIVE if row < V_ACTIVE-1, else VBLANK.
- VBLANK tick: col wraps as in HBLANK and row++. At col == H_TOTAL-1 and row == V_TOTAL-1:
  - row <= 0 and frame_done pulses.
  - Next state is IDLE if stop_pending, else ACTIVE.
- stop_pending: set by stop in any state, including IDLE with start in the same cycle (then exactly one frame runs). Cleared on entry to IDLE.
- pix_out holds its value outside ACTIVE ticks.
- div_enable = busy.
- hblank and vblank decode directly from state.

## Timing
- Reset: state IDLE, col=0, row=0, pix_out=0, pix_ready=0, frame_done=0, underrun=0, stop_pending=0, div_enable=0, pix_flag_q=0.
- start → busy/div_enable high the next cycle. With the standard divider, the first tick arrives on the 4th enabled cycle; after that, one tick every 4 clocks.
- pix_ready is asserted in the same cycle as the tick. pix_out is valid the following cycle.
- Frame length: H_TOTAL*V_TOTAL ticks. With defaults, 80 ticks = 320 clk.
- Reset mid-frame: everything returns to reset values immediately; no partial frame_done.
- stop during the last VBLANK tick cycle: still honoured at that frame end.
- pix_flag toggling while IDLE is ignored. pix_flag_q still tracks, so there is no spurious tick on restart.

## Structure
- Package pixel_scan_pkg: state enum scan_state_t, default geometry localparams, DATA_W.
- Sub-module scan_counter: col/row counters with tick-qualified increment and H_TOTAL/V_TOTAL wrap, plus end-of-line and end-of-frame outputs. The FSM, handshake and tick detection stay in the top level.
- The clock divider is instantiated by the parent, not inside this block.

## Test plan
- Reset, then toggle pix_flag with no start → all outputs 0, no pix_ready.
- start, pix_valid=1, pix_data=col+row*16, toggle pix_flag every 4 clk → 48 pix_ready strobes per frame, pix_out sequence matches, hblank 2 ticks/line, vblank 20 ticks, frame_done at tick 80.
- Drop pix_valid on the 3rd active tick of row 1 → pix_out=0 for that pixel, underrun=1 and sticky until next start, no pix_ready that tick.
- Assert stop mid-frame → frame completes, frame_done pulses, state goes to IDLE, div_enable=0, row=col=0.
- start and stop in the same IDLE cycle → exactly one frame (80 ticks) then IDLE. start asserted while busy → no effect.
- Assert n_rst low mid-ACTIVE at row 3 → immediate reset values. A later start begins at row=0, col=0.

Source files
------------

// File: rtl/pixel_scan_pkg.sv
// Shared types and default raster geometry for the pixel scan sequencer.
package pixel_scan_pkg;

    localparam int H_ACTIVE_DEF = 8;
    localparam int H_BLANK_DEF  = 2;
    localparam int V_ACTIVE_DEF = 6;
    localparam int V_BLANK_DEF  = 2;
    localparam int DATA_W       = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_HBLANK = 2'd2,
        ST_VBLANK = 2'd3
    } scan_state_t;

    // Counter width that never collapses to zero bits for degenerate geometries.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pixel_scan_ctrl_if.sv
// Upstream pixel stream: source presents valid/data, the scanner pops with ready.
interface pixel_scan_ctrl_if #(
    parameter int DATA_W = pixel_scan_pkg::DATA_W
) ();
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;

    modport master (output valid, output data, input  ready);
    modport slave  (input  valid, input  data, output ready);
endinterface

// File: rtl/pixel_scan_ctrl_scan_counter.sv
// Column/row raster counters advancing on qualified ticks, with line and frame end flags.
module scan_counter
    import pixel_scan_pkg::*;
#(
    parameter int H_TOTAL = H_ACTIVE_DEF + H_BLANK_DEF,
    parameter int V_TOTAL = V_ACTIVE_DEF + V_BLANK_DEF,
    parameter int COL_W   = cnt_w(H_TOTAL),
    parameter int ROW_W   = cnt_w(V_TOTAL)
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clr,
    input  logic             inc,
    output logic [COL_W-1:0] col,
    output logic [ROW_W-1:0] row,
    output logic             eol,
    output logic             eof
);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(H_TOTAL - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(V_TOTAL - 1);

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;

    assign eol = (col_q == COL_LAST);
    assign eof = eol && (row_q == ROW_LAST);

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (clr) begin
            col_d = '0;
            row_d = '0;
        end else if (inc) begin
            if (eol) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    assign col = col_q;
    assign row = row_q;

endmodule

// File: rtl/pixel_scan_ctrl.sv
// Frame scan sequencer: turns divider flag toggles into ticks, walks the raster
// and pops one upstream pixel per active tick.
module pixel_scan_ctrl
    import pixel_scan_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_BLANK  = H_BLANK_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_BLANK  = V_BLANK_DEF,
    parameter int DATA_W   = pixel_scan_pkg::DATA_W,
    localparam int H_TOTAL = H_ACTIVE + H_BLANK,
    localparam int V_TOTAL = V_ACTIVE + V_BLANK,
    localparam int COL_W   = cnt_w(H_TOTAL),
    localparam int ROW_W   = cnt_w(V_TOTAL)
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                start,
    input  logic                stop,
    input  logic                pix_flag,
    pixel_scan_ctrl_if.slave    pix_if,
    output logic                div_enable,
    output logic [DATA_W-1:0]   pix_out,
    output logic                hblank,
    output logic                vblank,
    output logic                frame_done,
    output logic                underrun,
    output logic                busy,
    output logic [COL_W-1:0]    col,
    output logic [ROW_W-1:0]    row
);

    localparam logic [COL_W-1:0] COL_ACT_LAST = COL_W'(H_ACTIVE - 1);
    localparam logic [ROW_W-1:0] ROW_ACT_LAST = ROW_W'(V_ACTIVE - 1);

    scan_state_t       state_q, state_d;
    logic              pix_flag_q, pix_flag_d;
    logic              stop_pending_q, stop_pending_d;
    logic              underrun_q, underrun_d;
    logic              frame_done_q, frame_done_d;
    logic [DATA_W-1:0] pix_out_q, pix_out_d;

    logic              tick;
    logic              pix_ready;
    logic              cnt_clr;
    logic              cnt_inc;
    logic              eol;
    logic              eof;
    logic              stop_now;

    // The divider toggles its flag once per pixel period; either edge is a tick.
    assign tick     = pix_flag ^ pix_flag_q;
    assign stop_now = stop_pending_q | stop;

    scan_counter #(
        .H_TOTAL (H_TOTAL),
        .V_TOTAL (V_TOTAL),
        .COL_W   (COL_W),
        .ROW_W   (ROW_W)
    ) u_scan_counter (
        .clk   (clk),
        .n_rst (n_rst),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .col   (col),
        .row   (row),
        .eol   (eol),
        .eof   (eof)
    );

    always_comb begin
        state_d        = state_q;
        pix_flag_d     = pix_flag;
        stop_pending_d = stop_pending_q | stop;
        underrun_d     = underrun_q;
        frame_done_d   = 1'b0;
        pix_out_d      = pix_out_q;
        pix_ready      = 1'b0;
        cnt_clr        = 1'b0;
        cnt_inc        = tick && (state_q != ST_IDLE);

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_ACTIVE;
                    cnt_clr    = 1'b1;
                    underrun_d = 1'b0;
                end
            end
            ST_ACTIVE: begin
                if (tick) begin
                    if (pix_if.valid) begin
                        pix_ready = 1'b1;
                        pix_out_d = pix_if.data;
                    end else begin
                        pix_out_d  = '0;
                        underrun_d = 1'b1;
                    end
                    if (col == COL_ACT_LAST) begin
                        state_d = ST_HBLANK;
                    end
                end
            end
            ST_HBLANK: begin
                if (tick && eol) begin
                    state_d = (row < ROW_ACT_LAST) ? ST_ACTIVE : ST_VBLANK;
                end
            end
            ST_VBLANK: begin
                if (tick && eof) begin
                    frame_done_d = 1'b1;
                    // A stop arriving on the very last tick still ends this frame.
                    if (stop_now) begin
                        state_d        = ST_IDLE;
                        stop_pending_d = 1'b0;
                    end else begin
                        state_d = ST_ACTIVE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q        <= ST_IDLE;
            pix_flag_q     <= 1'b0;
            stop_pending_q <= 1'b0;
            underrun_q     <= 1'b0;
            frame_done_q   <= 1'b0;
            pix_out_q      <= '0;
        end else begin
            state_q        <= state_d;
            pix_flag_q     <= pix_flag_d;
            stop_pending_q <= stop_pending_d;
            underrun_q     <= underrun_d;
            frame_done_q   <= frame_done_d;
            pix_out_q      <= pix_out_d;
        end
    end

    assign pix_if.ready = pix_ready;
    assign busy         = (state_q != ST_IDLE);
    assign div_enable   = busy;
    assign hblank       = (state_q == ST_HBLANK);
    assign vblank       = (state_q == ST_VBLANK);
    assign frame_done   = frame_done_q;
    assign underrun     = underrun_q;
    assign pix_out      = pix_out_q;

endmodule

// File: tb/tb_pixel_scan_ctrl.sv
// Directed bench for pixel_scan_ctrl: a per-tick raster table applied frame by frame,
// plus hand-written start/stop/reset sequences.
module tb_pixel_scan_ctrl;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       start;
    logic       stop;
    logic       pix_flag;
    logic       div_enable;
    logic [7:0] pix_out;
    logic       hblank;
    logic       vblank;
    logic       frame_done;
    logic       underrun;
    logic       busy;
    logic [3:0] col;
    logic [2:0] row;

    pixel_scan_ctrl_if #(.DATA_W(8)) pif ();

    pixel_scan_ctrl dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .start      (start),
        .stop       (stop),
        .pix_flag   (pix_flag),
        .pix_if     (pif.slave),
        .div_enable (div_enable),
        .pix_out    (pix_out),
        .hblank     (hblank),
        .vblank     (vblank),
        .frame_done (frame_done),
        .underrun   (underrun),
        .busy       (busy),
        .col        (col),
        .row        (row)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       valid;
        logic [7:0] data;
        logic       exp_ready;
        logic       exp_hblank;
        logic       exp_vblank;
        logic       exp_fd;
        logic [3:0] exp_col;
        logic [2:0] exp_row;
        logic       chk_pix;
        logic [7:0] exp_pix;
    } vec_t;

    vec_t tab [80];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    // One table vector per tick; inputs change 1ns after a rising edge.
    task automatic run_frame(input int n_ticks, input int drop_idx, input int stop_idx,
                             input int start_idx, input string tag);
        for (int i = 0; i < n_ticks; i++) begin
            logic       v;
            logic       er;
            logic [7:0] ep;
            v  = tab[i].valid && (i != drop_idx);
            er = tab[i].exp_ready && (i != drop_idx);
            ep = (i == drop_idx) ? 8'h00 : tab[i].exp_pix;
            pif.valid = v;
            pif.data  = tab[i].data;
            stop      = (i == stop_idx);
            start     = (i == start_idx);
            pix_flag  = ~pix_flag;
            #1;
            chk($sformatf("%s ready[%0d]", tag, i), pif.ready, er);
            chk($sformatf("%s hblank[%0d]", tag, i), hblank, tab[i].exp_hblank);
            chk($sformatf("%s vblank[%0d]", tag, i), vblank, tab[i].exp_vblank);
            chk($sformatf("%s col[%0d]", tag, i), col, tab[i].exp_col);
            chk($sformatf("%s row[%0d]", tag, i), row, tab[i].exp_row);
            chk($sformatf("%s busy[%0d]", tag, i), busy, 1'b1);
            clk1();
            stop  = 1'b0;
            start = 1'b0;
            if (tab[i].chk_pix)
                chk($sformatf("%s pix_out[%0d]", tag, i), pix_out, ep);
            chk($sformatf("%s frame_done[%0d]", tag, i), frame_done, tab[i].exp_fd);
            if (i == drop_idx)
                chk($sformatf("%s underrun[%0d]", tag, i), underrun, 1'b1);
            repeat (3) clk1();
        end
        $display("[TB] %s: %0d ticks applied, errors so far %0d", tag, n_ticks, n_fail);
    endtask

    task automatic do_start(input logic with_stop);
        start = 1'b1;
        stop  = with_stop;
        clk1();
        start = 1'b0;
        stop  = 1'b0;
        chk("start busy", busy, 1'b1);
        chk("start div_enable", div_enable, 1'b1);
        chk("start underrun clr", underrun, 1'b0);
        chk("start col", col, 4'd0);
        chk("start row", row, 3'd0);
        repeat (2) clk1();
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " busy"}, busy, 1'b0);
        chk({tag, " div_enable"}, div_enable, 1'b0);
        chk({tag, " col"}, col, 4'd0);
        chk({tag, " row"}, row, 3'd0);
        chk({tag, " hblank"}, hblank, 1'b0);
        chk({tag, " vblank"}, vblank, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 80; i++) begin
            int r;
            int c;
            r = i / 10;
            c = i % 10;
            tab[i].valid      = 1'b1;
            tab[i].data       = 8'(c + r * 16);
            tab[i].exp_ready  = (r < 6) && (c < 8);
            tab[i].exp_hblank = (r < 6) && (c >= 8);
            tab[i].exp_vblank = (r >= 6);
            tab[i].exp_fd     = (i == 79);
            tab[i].exp_col    = 4'(c);
            tab[i].exp_row    = 3'(r);
            tab[i].chk_pix    = (r < 6) && (c < 8);
            tab[i].exp_pix    = 8'(c + r * 16);
        end

        n_rst     = 1'b0;
        start     = 1'b0;
        stop      = 1'b0;
        pix_flag  = 1'b0;
        pif.valid = 1'b0;
        pif.data  = 8'h00;
        repeat (3) clk1();
        chk_idle("reset");
        chk("reset pix_ready", pif.ready, 1'b0);
        chk("reset pix_out", pix_out, 8'h00);
        chk("reset frame_done", frame_done, 1'b0);
        chk("reset underrun", underrun, 1'b0);
        n_rst = 1'b1;
        clk1();

        // Flag toggles while idle must not pop pixels or move the raster.
        pif.valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            pix_flag = ~pix_flag;
            #1;
            chk($sformatf("idle ready[%0d]", k), pif.ready, 1'b0);
            repeat (2) clk1();
            chk($sformatf("idle busy[%0d]", k), busy, 1'b0);
            chk($sformatf("idle col[%0d]", k), col, 4'd0);
        end
        $display("[TB] idle toggles: done, errors so far %0d", n_fail);

        // Frame A: continuous valid, start pulsed mid-frame is ignored.
        do_start(1'b0);
        run_frame(80, -1, -1, 30, "frame A");
        chk("A busy after", busy, 1'b1);
        chk("A underrun", underrun, 1'b0);
        chk("A col wrap", col, 4'd0);
        chk("A row wrap", row, 3'd0);

        // Frame B: underrun on row 1 col 2, stop requested mid-frame.
        run_frame(80, 12, 40, -1, "frame B");
        chk_idle("B end");
        chk("B underrun sticky", underrun, 1'b1);
        chk("B pix_out hold", pix_out, 8'h57);

        // Frame C: start and stop together -> exactly one frame.
        do_start(1'b1);
        run_frame(80, -1, -1, -1, "frame C");
        chk_idle("C end");

        // Frame D: stop arrives only on the final tick.
        do_start(1'b0);
        run_frame(80, -1, 79, -1, "frame D");
        chk_idle("D end");

        // Frame E: reset in the middle of row 3.
        do_start(1'b0);
        run_frame(33, -1, -1, -1, "frame E");
        chk("E pre-reset row", row, 3'd3);
        n_rst = 1'b0;
        #1;
        chk_idle("E reset");
        chk("E reset pix_out", pix_out, 8'h00);
        chk("E reset ready", pif.ready, 1'b0);
        repeat (2) clk1();
        chk("E reset frame_done", frame_done, 1'b0);
        n_rst = 1'b1;
        clk1();
        $display("[TB] mid-frame reset: done, errors so far %0d", n_fail);

        // Frame F: fresh start after reset begins at origin.
        do_start(1'b0);
        run_frame(80, -1, 0, -1, "frame F");
        chk_idle("F end");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
